uart_rx_fifo: RTL and testbench



---
 rtl/uart_rx_fifo.sv | 130 +++++++++++++
 tb/tb_uart_rx_fifo.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: receive-side byte buffer placed after the UART receiver.
// Power-of-two circular buffer with first-word-fall-through read, a
// registered occupancy counter, almost-full warning and overflow/underflow
// reporting.
// Build option: define UART_RXFIFO_STICKY_OVF_EN to make overflow a sticky
// flag cleared by ovf_clr, flush or rst; otherwise overflow is a one-cycle
// pulse per dropped byte and ovf_clr is ignored.
module uart_rx_fifo #(
  parameter int unsigned DEPTH        = 16,
  parameter int unsigned AFULL_THRESH = 12
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush,
  input  logic                       wr_en,
  input  logic [7:0]                 wr_data,
  input  logic                       rd_en,
  output logic [7:0]                 rd_data,
  output logic                       rd_valid,
  output logic [$clog2(DEPTH):0]     level,
  output logic                       empty,
  output logic                       full,
  output logic                       afull,
  output logic                       overflow,
  output logic                       underflow,
  input  logic                       ovf_clr
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned LW = PW + 1;

  logic [7:0]    mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [LW-1:0] level_q;
  logic          pop;
  logic          wr_ok;
  logic          wr_drop;
  logic          ovf_q;
  logic          unf_q;

  // Status flags follow the registered level directly
  always_comb begin
    level    = level_q;
    empty    = (level_q == '0);
    full     = (level_q == LW'(DEPTH));
    afull    = (level_q >= LW'(AFULL_THRESH));
    rd_valid = !empty;
    rd_data  = mem[rd_ptr];
  end

  // Request qualification; a pop frees a slot so a full buffer still accepts
  always_comb begin
    pop     = rd_en && !empty;
    wr_ok   = wr_en && (!full || pop);
    wr_drop = wr_en && full && !pop;
  end

  // Byte storage; not reset, contents are only visible through rd_ptr
  always_ff @(posedge clk) begin
    if (!flush && wr_ok) begin
      mem[wr_ptr] <= wr_data;
    end
  end

  // Pointers and occupancy counter; flush overrides any same-cycle traffic
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      level_q <= '0;
    end else if (flush) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      level_q <= '0;
    end else begin
      if (wr_ok) begin
        wr_ptr <= wr_ptr + PW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PW'(1);
      end
      case ({wr_ok, pop})
        2'b10:   level_q <= level_q + LW'(1);
        2'b01:   level_q <= level_q - LW'(1);
        default: level_q <= level_q;
      endcase
    end
  end

  // Underflow pulse: pop requested while empty, suppressed by flush
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      unf_q <= 1'b0;
    end else begin
      unf_q <= rd_en && empty && !flush;
    end
  end

`ifdef UART_RXFIFO_STICKY_OVF_EN
  // Sticky overflow; a new drop wins over a same-cycle clear
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ovf_q <= 1'b0;
    end else if (flush) begin
      ovf_q <= 1'b0;
    end else if (wr_drop) begin
      ovf_q <= 1'b1;
    end else if (ovf_clr) begin
      ovf_q <= 1'b0;
    end
  end
`else
  logic unused_ovf_clr;
  assign unused_ovf_clr = ovf_clr;

  // One-cycle overflow pulse per dropped byte
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ovf_q <= 1'b0;
    end else begin
      ovf_q <= wr_drop && !flush;
    end
  end
`endif

  assign overflow  = ovf_q;
  assign underflow = unf_q;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Self-checking bench for uart_rx_fifo (DEPTH=16, AFULL_THRESH=12) with a
// byte scoreboard: accepted writes are queued, pops compare the head.
module tb_uart_rx_fifo;

  localparam int unsigned DEPTH = 16;
  localparam int unsigned THR   = 12;

  logic       clk = 1'b0;
  logic       rst, flush, wr_en, rd_en, ovf_clr;
  logic [7:0] wr_data, rd_data;
  logic       rd_valid, empty, full, afull, overflow, underflow;
  logic [4:0] level;

  int total = 0;
  int bad   = 0;
  logic [7:0] sb [$];

  always #5 clk = ~clk;

  uart_rx_fifo #(.DEPTH(DEPTH), .AFULL_THRESH(THR)) dut (
    .clk(clk), .rst(rst), .flush(flush), .wr_en(wr_en), .wr_data(wr_data),
    .rd_en(rd_en), .rd_data(rd_data), .rd_valid(rd_valid), .level(level),
    .empty(empty), .full(full), .afull(afull), .overflow(overflow),
    .underflow(underflow), .ovf_clr(ovf_clr)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One write cycle; the byte enters the scoreboard only if it should be kept
  task automatic write_byte(input logic [7:0] b, input bit keep);
    wr_en = 1'b1; wr_data = b;
    step();
    wr_en = 1'b0;
    if (keep) sb.push_back(b);
  endtask

  // Pop everything the scoreboard holds, checking order and final emptiness
  task automatic drain(input string tag);
    int n;
    logic [7:0] exp_b;
    n = sb.size();
    for (int i = 0; i < n; i++) begin
      exp_b = sb.pop_front();
      total++;
      if (rd_valid !== 1'b1 || rd_data !== exp_b) begin
        bad++;
        $display("FAIL %s_data[%0d]: got valid=%b data=%02h, want valid=1 data=%02h",
                 tag, i, rd_valid, rd_data, exp_b);
      end
      rd_en = 1'b1;
      step();
      rd_en = 1'b0;
    end
    total++;
    if (empty !== 1'b1 || level !== 5'd0) begin
      bad++;
      $display("FAIL %s_empty: got empty=%b level=%0d, want empty=1 level=0", tag, empty, level);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; flush = 0; wr_en = 0; rd_en = 0; ovf_clr = 0; wr_data = '0;
    #12;
    total++;
    if ({empty, full, afull, rd_valid, overflow, underflow} !== 6'b100000 || level !== 5'd0) begin
      bad++;
      $display("FAIL reset: got e/f/af/v/o/u=%b%b%b%b%b%b level=%0d, want 100000 level=0",
               empty, full, afull, rd_valid, overflow, underflow, level);
    end
    @(negedge clk);
    rst = 1'b0;
    step();
  endtask

  task automatic test_single();
    write_byte(8'hA5, 1);
    total++;
    if (rd_valid !== 1'b1 || rd_data !== 8'hA5 || level !== 5'd1) begin
      bad++;
      $display("FAIL single_wr: got v=%b data=%02h level=%0d, want v=1 data=a5 level=1",
               rd_valid, rd_data, level);
    end
    drain("single");
  endtask

  // Fill to full checking thresholds each step; pointers start offset by one
  // so the fill wraps the write pointer
  task automatic test_fill(input logic [7:0] base);
    for (int i = 0; i < DEPTH; i++) begin
      write_byte(base + 8'(i), 1);
      total++;
      if (level !== 5'(i + 1) || afull !== ((i + 1) >= THR) || full !== ((i + 1) == DEPTH)) begin
        bad++;
        $display("FAIL fill_lvl[%0d]: got level=%0d afull=%b full=%b, want level=%0d afull=%b full=%b",
                 i, level, afull, full, i + 1, (i + 1) >= THR, (i + 1) == DEPTH);
      end
    end
  endtask

  task automatic test_overflow();
    test_fill(8'h20);
    write_byte(8'h55, 0);
    total++;
    if (overflow !== 1'b1 || level !== 5'd16) begin
      bad++;
      $display("FAIL ovf_set: got ovf=%b level=%0d, want ovf=1 level=16", overflow, level);
    end
    step();
`ifdef UART_RXFIFO_STICKY_OVF_EN
    total++;
    if (overflow !== 1'b1) begin
      bad++;
      $display("FAIL ovf_hold: got %b want 1", overflow);
    end
    ovf_clr = 1'b1; step(); ovf_clr = 1'b0;
    total++;
    if (overflow !== 1'b0) begin
      bad++;
      $display("FAIL ovf_clr: got %b want 0", overflow);
    end
`else
    total++;
    if (overflow !== 1'b0) begin
      bad++;
      $display("FAIL ovf_pulse: got %b want 0 one cycle later", overflow);
    end
`endif
    drain("ovf");
  endtask

  task automatic test_full_wr_pop();
    logic [7:0] head;
    test_fill(8'h40);
    head = sb.pop_front();
    total++;
    if (rd_data !== head) begin
      bad++;
      $display("FAIL fwp_head: got %02h want %02h", rd_data, head);
    end
    wr_en = 1'b1; wr_data = 8'h77; rd_en = 1'b1;
    step();
    wr_en = 1'b0; rd_en = 1'b0;
    sb.push_back(8'h77);
    total++;
    if (level !== 5'd16 || full !== 1'b1 || overflow !== 1'b0) begin
      bad++;
      $display("FAIL fwp_lvl: got level=%0d full=%b ovf=%b, want 16 1 0", level, full, overflow);
    end
    drain("fwp");
  endtask

  task automatic test_underflow();
    wr_en = 1'b1; wr_data = 8'h3C; rd_en = 1'b1;
    step();
    wr_en = 1'b0; rd_en = 1'b0;
    sb.push_back(8'h3C);
    total++;
    if (underflow !== 1'b1 || level !== 5'd1 || rd_data !== 8'h3C) begin
      bad++;
      $display("FAIL unf: got unf=%b level=%0d data=%02h, want 1 1 3c", underflow, level, rd_data);
    end
    step();
    total++;
    if (underflow !== 1'b0) begin
      bad++;
      $display("FAIL unf_pulse: got %b want 0", underflow);
    end
    drain("unf");
  endtask

  task automatic test_flush();
    for (int i = 0; i < 5; i++) write_byte(8'h60 + 8'(i), 0);
    total++;
    if (level !== 5'd5) begin
      bad++;
      $display("FAIL flush_pre: got level=%0d want 5", level);
    end
    flush = 1'b1; wr_en = 1'b1; wr_data = 8'h99; rd_en = 1'b1;
    step();
    flush = 1'b0; wr_en = 1'b0; rd_en = 1'b0;
    total++;
    if (level !== 5'd0 || empty !== 1'b1 || overflow !== 1'b0 || rd_valid !== 1'b0) begin
      bad++;
      $display("FAIL flush: got level=%0d empty=%b ovf=%b v=%b, want 0 1 0 0",
               level, empty, overflow, rd_valid);
    end
    step();
    total++;
    if (underflow !== 1'b0 || level !== 5'd0) begin
      bad++;
      $display("FAIL flush_quiet: got unf=%b level=%0d, want 0 0", underflow, level);
    end
    write_byte(8'hC3, 1);
    drain("postflush");
  endtask

  task automatic test_back_to_back();
    // Stream with a write and a pop every cycle after a one-entry prime
    write_byte(8'h80, 1);
    for (int i = 1; i < 24; i++) begin
      total++;
      if (rd_data !== sb[0] || level !== 5'd1) begin
        bad++;
        $display("FAIL b2b[%0d]: got data=%02h level=%0d, want %02h 1", i, rd_data, level, sb[0]);
      end
      wr_en = 1'b1; wr_data = 8'h80 + 8'(i); rd_en = 1'b1;
      step();
      void'(sb.pop_front());
      sb.push_back(8'h80 + 8'(i));
    end
    wr_en = 1'b0; rd_en = 1'b0;
    drain("b2b");
  endtask

  initial begin
    test_reset();
    test_single();
    test_fill(8'h00);
    drain("fill1");
    test_fill(8'h10);
    drain("fill2");
    test_overflow();
    test_full_wr_pop();
    test_underflow();
    test_flush();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end

endmodule
